ex_mem_fwd_ctrl: RTL and testbench
==================================

# ex_mem_fwd_ctrl

EX/MEM pipeline register plus hazard controller for the 5-stage core. It latches the execute-stage result and control bits each cycle. It drives the `FA`/`FB` forwarding selects consumed by the execute-stage ALU and stalls the front end on load-use hazards. It is the producer side of the execute-stage forwarding interface and sits between the EX and MEM stages, with a side path back to IF/ID.

## Interface
Clock is `clk`; reset `rst_n` is asynchronous, active-low.

Parameters:
- `DATA_W`, 32: datapath width.
- `REG_AW`, 4: register address width; register 0 is hardwired zero.
- `LU_STALLS`, 1: bubbles inserted per load-use hazard, range 1–3.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: async active-low reset.
- `id_ex_rs1`, `id_ex_rs2` in REG_AW: EX-stage source registers.
- `id_ex_rd` in REG_AW: EX-stage destination register.
- `id_ex_rw`, `id_ex_mr`, `id_ex_mw` in 1: EX-stage reg-write, mem-read and mem-write flags.
- `id_ex_alu_src` in 1: EX-stage immediate select.
- `alu_result` in DATA_W: combinational ALU result from EX.
- `rd2_2` in DATA_W: store data from EX, already forwarded.
- `if_id_rs1`, `if_id_rs2` in REG_AW: ID-stage source registers.
- `FA`, `FB` out 1: forwarding selects to EX.
- `alu_result_1` out DATA_W: registered EX/MEM result; also the forwarding source.
- `ex_mem_wdata` out DATA_W: registered store data.
- `ex_mem_rd` out REG_AW: registered destination.
- `ex_mem_rw`, `ex_mem_mr`, `ex_mem_mw` out 1: registered control flags.
- `pc_write`, `if_id_write` out 1: front-end enables; 0 means hold.
- `id_ex_bubble` out 1: zero the ID/EX control bits this cycle.

## Operation
- EX/MEM register: loads every rising edge, with no enable. Fields: `alu_result`→`alu_result_1`, `rd2_2`→`ex_mem_wdata`, `id_ex_rd`, `id_ex_rw`, `id_ex_mr`, `id_ex_mw`.
- Forward-valid: `fv` = `ex_mem_rw` & !`ex_mem_mr` & (`ex_mem_rd` != 0). Load data is never forwarded from EX/MEM.
- `FA` = `fv` & (`ex_mem_rd` == `id_ex_rs1`).
- `FB` = `fv` & (`ex_mem_rd` == `id_ex_rs2`) & (`id_ex_mw` | !`id_ex_alu_src`).
  - For stores, `FB` forwards the store data while the ALU keeps the immediate.
  - For non-store immediate ops, `FB` is 0.
- Hazard detect: `haz` = `id_ex_mr` & (`id_ex_rd` != 0) & (`id_ex_rd` == `if_id_rs1` | `id_ex_rd` == `if_id_rs2`).
- FSM states:
  - RUN → STALL when `haz`; load `cnt` = `LU_STALLS`-1.
  - STALL: decrement `cnt`; return to RUN when `cnt` == 0.
- Outputs in STALL, and in RUN while `haz` is true (combinational, so the first bubble lands in the detect cycle): `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1.
- While in STALL, `haz` is ignored. The bubble clears `id_ex_mr`, so there is no self-retrigger.

## Timing
- Reset values: all registered outputs 0, FSM=RUN, `cnt`=0. Hence `FA`=`FB`=0, `pc_write`=`if_id_write`=1, `id_ex_bubble`=0.
- Reset is asynchronous. Asserting it mid-stall returns the FSM to RUN immediately, and the stall outputs deassert in the same cycle.
- EX→EX/MEM latency is 1 cycle. `FA`/`FB` are purely combinational from current ID/EX inputs and registered EX/MEM state, with zero latency.
- A load-use hazard costs exactly `LU_STALLS` cycles of `pc_write`=0, counting the detect cycle.
- Simultaneous cases:
  - rs1 == rs2 == `ex_mem_rd`: `FA` and `FB` both 1.
  - `haz` and `fv` in the same cycle: independent; both act.

## Structure
- A shared package `core_pkg` holds the `DATA_W`/`REG_AW` defaults, the `REG_ZERO` constant, and the FSM state enum {RUN, STALL}.
- Natural split: a sub-module `hazard_fsm` containing the detect logic, the counter and the stall outputs. The EX/MEM register and the forwarding compare stay in the top level.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs at reset values; `pc_write`=1.
- ALU→ALU forward: cycle N has rd=3, rw=1, result 0x0000_0010. At N+1, `id_ex_rs1`=3 and `rs2`=3 with `alu_src`=0 → `FA`=`FB`=1, `alu_result_1`=0x10.
- Store data forward: EX/MEM has rd=5, rw=1. EX is a store with rs2=5, `mw`=1, `alu_src`=1 → `FB`=1, `FA`=0.
- Immediate op and x0:
  - `alu_src`=1, `mw`=0, rs2 matches → `FB`=0.
  - rd=0, rw=1 with matching sources → `FA`=`FB`=0.
- Load-use: `id_ex_mr`=1, rd=7, `if_id_rs2`=7.
  - `LU_STALLS`=1 → one cycle with `pc_write`=0 and `id_ex_bubble`=1.
  - `LU_STALLS`=3 → three cycles.
  - In both cases the next cycle shows no `FA` from the load, since `ex_mem_mr`=1.
- Reset mid-stall: `LU_STALLS`=3, assert `rst_n`=0 in the second stall cycle → `pc_write` returns to 1 immediately; FSM is RUN after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the execute/memory boundary of the 5-stage core:
// datapath defaults, the hardwired-zero register index and hazard FSM states.
package core_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 4;

  // Register index 0 always reads as zero and is never a forwarding source.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/hazard_fsm.sv
// Load-use hazard detector. Holds the front end and bubbles ID/EX for
// LU_STALLS cycles, the first of which is the detect cycle itself.
module hazard_fsm
  import core_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int LU_STALLS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_ex_mr_i,
  input  logic [REG_AW-1:0] id_ex_rd_i,
  input  logic [REG_AW-1:0] if_id_rs1_i,
  input  logic [REG_AW-1:0] if_id_rs2_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              id_ex_bubble_o
);

  fsm_state_e state_q, state_d;
  // Remaining stall cycles after the current one.
  logic [1:0] cnt_q, cnt_d;
  logic       haz;
  logic       stall;

  assign haz = id_ex_mr_i
             & (id_ex_rd_i != REG_AW'(REG_ZERO))
             & ((id_ex_rd_i == if_id_rs1_i) | (id_ex_rd_i == if_id_rs2_i));

  // State and counter registers; async reset returns to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and stall request; a single-cycle stall never leaves RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (haz) begin
          stall = 1'b1;
          if (LU_STALLS > 1) begin
            state_d = STALL;
            cnt_d   = 2'(LU_STALLS - 1);
          end
        end
      end
      STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_d == 2'd0) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Gate with reset so a hazard on the inputs cannot hold the front end in reset.
  assign pc_write_o     = ~(stall & rst_n);
  assign if_id_write_o  = ~(stall & rst_n);
  assign id_ex_bubble_o = stall & rst_n;

endmodule

// File: rtl/ex_mem_fwd_ctrl.sv
// EX/MEM pipeline register with EX-stage forwarding selects and the
// load-use stall controller for the front end.
module ex_mem_fwd_ctrl
  import core_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int REG_AW    = REG_AW_DEF,
  parameter int LU_STALLS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_ex_rs1,
  input  logic [REG_AW-1:0] id_ex_rs2,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_rw,
  input  logic              id_ex_mr,
  input  logic              id_ex_mw,
  input  logic              id_ex_alu_src,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rd2_2,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  output logic              FA,
  output logic              FB,
  output logic [DATA_W-1:0] alu_result_1,
  output logic [DATA_W-1:0] ex_mem_wdata,
  output logic [REG_AW-1:0] ex_mem_rd,
  output logic              ex_mem_rw,
  output logic              ex_mem_mr,
  output logic              ex_mem_mw,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble
);

  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] wdata_q;
  logic [REG_AW-1:0] rd_q;
  logic              rw_q;
  logic              mr_q;
  logic              mw_q;
  logic              fv;

  // EX/MEM register: loads every cycle, no enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      mr_q         <= 1'b0;
      mw_q         <= 1'b0;
    end else begin
      alu_result_q <= alu_result;
      wdata_q      <= rd2_2;
      rd_q         <= id_ex_rd;
      rw_q         <= id_ex_rw;
      mr_q         <= id_ex_mr;
      mw_q         <= id_ex_mw;
    end
  end

  assign alu_result_1 = alu_result_q;
  assign ex_mem_wdata = wdata_q;
  assign ex_mem_rd    = rd_q;
  assign ex_mem_rw    = rw_q;
  assign ex_mem_mr    = mr_q;
  assign ex_mem_mw    = mw_q;

  // Load data is not available in EX/MEM yet, so loads never forward from here.
  assign fv = rw_q & ~mr_q & (rd_q != REG_AW'(REG_ZERO));

  // FB also covers store data: the ALU keeps its immediate while the store
  // operand takes the forwarded value. Non-store immediate ops never use rs2.
  assign FA = fv & (rd_q == id_ex_rs1);
  assign FB = fv & (rd_q == id_ex_rs2) & (id_ex_mw | ~id_ex_alu_src);

  hazard_fsm #(
    .REG_AW    (REG_AW),
    .LU_STALLS (LU_STALLS)
  ) u_hazard_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_ex_mr_i     (id_ex_mr),
    .id_ex_rd_i     (id_ex_rd),
    .if_id_rs1_i    (if_id_rs1),
    .if_id_rs2_i    (if_id_rs2),
    .pc_write_o     (pc_write),
    .if_id_write_o  (if_id_write),
    .id_ex_bubble_o (id_ex_bubble)
  );

endmodule

// File: tb/tb_ex_mem_fwd_ctrl.sv
// Directed bench: one instance with single-cycle load-use stalls and one
// with three-cycle stalls, sharing all inputs.
module tb_ex_mem_fwd_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic          id_ex_rw, id_ex_mr, id_ex_mw, id_ex_alu_src;
  logic [DW-1:0] alu_result, rd2_2;
  logic [AW-1:0] if_id_rs1, if_id_rs2;

  logic          a_fa, a_fb, a_rw, a_mr, a_mw, a_pcw, a_ifw, a_bub;
  logic [DW-1:0] a_res, a_wdata;
  logic [AW-1:0] a_rd;
  logic          b_fa, b_fb, b_rw, b_mr, b_mw, b_pcw, b_ifw, b_bub;
  logic [DW-1:0] b_res, b_wdata;
  logic [AW-1:0] b_rd;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_mem_fwd_ctrl #(.DATA_W(DW), .REG_AW(AW), .LU_STALLS(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_rw(id_ex_rw), .id_ex_mr(id_ex_mr), .id_ex_mw(id_ex_mw),
    .id_ex_alu_src(id_ex_alu_src), .alu_result(alu_result), .rd2_2(rd2_2),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .FA(a_fa), .FB(a_fb), .alu_result_1(a_res), .ex_mem_wdata(a_wdata),
    .ex_mem_rd(a_rd), .ex_mem_rw(a_rw), .ex_mem_mr(a_mr), .ex_mem_mw(a_mw),
    .pc_write(a_pcw), .if_id_write(a_ifw), .id_ex_bubble(a_bub)
  );

  ex_mem_fwd_ctrl #(.DATA_W(DW), .REG_AW(AW), .LU_STALLS(3)) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_rw(id_ex_rw), .id_ex_mr(id_ex_mr), .id_ex_mw(id_ex_mw),
    .id_ex_alu_src(id_ex_alu_src), .alu_result(alu_result), .rd2_2(rd2_2),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .FA(b_fa), .FB(b_fb), .alu_result_1(b_res), .ex_mem_wdata(b_wdata),
    .ex_mem_rd(b_rd), .ex_mem_rw(b_rw), .ex_mem_mr(b_mr), .ex_mem_mw(b_mw),
    .pc_write(b_pcw), .if_id_write(b_ifw), .id_ex_bubble(b_bub)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0;
    id_ex_rw = 1'b0; id_ex_mr = 1'b0; id_ex_mw = 1'b0; id_ex_alu_src = 1'b0;
    alu_result = '0; rd2_2 = '0; if_id_rs1 = '0; if_id_rs2 = '0;
  endtask

  initial begin
    // Reset held with random inputs
    rst_n = 1'b0;
    id_ex_rs1 = AW'($urandom); id_ex_rs2 = AW'($urandom); id_ex_rd = AW'($urandom);
    id_ex_rw = 1'b1; id_ex_mr = 1'b1; id_ex_mw = 1'($urandom); id_ex_alu_src = 1'($urandom);
    alu_result = $urandom; rd2_2 = $urandom;
    if_id_rs1 = id_ex_rd; if_id_rs2 = AW'($urandom);
    tick(); tick(); #1;
    chk("rst_fa", a_fa, 0);
    chk("rst_fb", a_fb, 0);
    chk("rst_res", a_res, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_flags", {a_rw, a_mr, a_mw}, 0);
    chk("rst_pcw_s1", a_pcw, 1);
    chk("rst_ifw_s1", a_ifw, 1);
    chk("rst_bub_s1", a_bub, 0);
    chk("rst_pcw_s3", b_pcw, 1);
    idle_inputs();
    #1 rst_n = 1'b1;

    // ALU -> ALU forward on both operands
    tick();
    id_ex_rd = 4'd3; id_ex_rw = 1'b1; alu_result = 32'h0000_0010; rd2_2 = 32'h0000_00AA;
    tick();
    idle_inputs();
    id_ex_rs1 = 4'd3; id_ex_rs2 = 4'd3; id_ex_alu_src = 1'b0;
    #1;
    chk("alu_fa", a_fa, 1);
    chk("alu_fb", a_fb, 1);
    chk("alu_res", a_res, 32'h10);
    chk("alu_wdata", a_wdata, 32'hAA);
    chk("alu_rd", a_rd, 3);
    chk("alu_rw", a_rw, 1);

    // Store data forward, immediate op blocking FB
    id_ex_rd = 4'd5; id_ex_rw = 1'b1; alu_result = 32'h55; id_ex_rs1 = 4'd0; id_ex_rs2 = 4'd0;
    tick();
    idle_inputs();
    id_ex_rs1 = 4'd4; id_ex_rs2 = 4'd5; id_ex_mw = 1'b1; id_ex_alu_src = 1'b1;
    #1;
    chk("st_fb", a_fb, 1);
    chk("st_fa", a_fa, 0);
    id_ex_mw = 1'b0; id_ex_alu_src = 1'b1;
    #1;
    chk("imm_fb", a_fb, 0);
    id_ex_alu_src = 1'b0;
    #1;
    chk("reg_fb", a_fb, 1);

    // x0 is never forwarded
    idle_inputs();
    id_ex_rd = 4'd0; id_ex_rw = 1'b1;
    tick();
    idle_inputs();
    #1;
    chk("x0_fa", a_fa, 0);
    chk("x0_fb", a_fb, 0);

    // Load-use: rd=7 load in EX, consumer rs2=7 in ID
    id_ex_mr = 1'b1; id_ex_rd = 4'd7; id_ex_rw = 1'b1; if_id_rs1 = 4'd2; if_id_rs2 = 4'd7;
    #1;
    chk("lu_pcw_s1_c0", a_pcw, 0);
    chk("lu_ifw_s1_c0", a_ifw, 0);
    chk("lu_bub_s1_c0", a_bub, 1);
    chk("lu_pcw_s3_c0", b_pcw, 0);
    tick();
    idle_inputs();
    if_id_rs2 = 4'd7; id_ex_rs1 = 4'd7; id_ex_rs2 = 4'd7;
    #1;
    chk("lu_pcw_s1_c1", a_pcw, 1);
    chk("lu_bub_s1_c1", a_bub, 0);
    chk("lu_pcw_s3_c1", b_pcw, 0);
    chk("lu_bub_s3_c1", b_bub, 1);
    chk("lu_exmr", a_mr, 1);
    chk("lu_no_fa", a_fa, 0);
    chk("lu_no_fb", b_fb, 0);
    tick();
    chk("lu_pcw_s3_c2", b_pcw, 0);
    chk("lu_pcw_s1_c2", a_pcw, 1);
    tick();
    chk("lu_pcw_s3_c3", b_pcw, 1);
    chk("lu_ifw_s3_c3", b_ifw, 1);

    // Hazard and forwarding in the same cycle act independently
    idle_inputs();
    id_ex_rd = 4'd6; id_ex_rw = 1'b1;
    tick();
    idle_inputs();
    id_ex_rs1 = 4'd6; id_ex_mr = 1'b1; id_ex_rd = 4'd8; id_ex_rw = 1'b1; if_id_rs1 = 4'd8;
    #1;
    chk("both_fa", a_fa, 1);
    chk("both_pcw", a_pcw, 0);
    tick();
    idle_inputs();
    tick(); tick();
    chk("both_done_s3", b_pcw, 1);

    // Reset asserted in the second stall cycle
    id_ex_mr = 1'b1; id_ex_rd = 4'd7; if_id_rs2 = 4'd7;
    tick();
    idle_inputs();
    #1;
    chk("rms_pcw_before", b_pcw, 0);
    rst_n = 1'b0;
    #1;
    chk("rms_pcw_async", b_pcw, 1);
    chk("rms_bub_async", b_bub, 0);
    chk("rms_rd_clr", b_rd, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("rms_run_1", b_pcw, 1);
    tick();
    chk("rms_run_2", b_pcw, 1);

    // A fresh hazard after reset still costs exactly three cycles
    id_ex_mr = 1'b1; id_ex_rd = 4'd9; if_id_rs1 = 4'd9;
    #1;
    chk("re_c0", b_pcw, 0);
    tick();
    idle_inputs();
    #1;
    chk("re_c1", b_pcw, 0);
    tick();
    chk("re_c2", b_pcw, 0);
    tick();
    chk("re_c3", b_pcw, 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
